// File: rtl/stage30_flit_output_arbiter_if.sv
// Flit type shared by the stage-30 output arbiter and its bus interface.
package types;
  localparam int FLIT_W = 32;
  typedef logic [FLIT_W-1:0] flit_t;
endpackage

// Bus bundle for the stage-30 output arbiter: two producer paths,
// the merged downstream stream, and the overflow reporting.
interface stage30_flit_output_arbiter_if #(
  parameter int DROP_CNT_WIDTH = 8
);
  logic                      in_sys_flit_valid;
  types::flit_t              in_sys_flit;
  logic                      out_sys_ready;
  logic                      in_normal_flit_valid;
  types::flit_t              in_normal_flit;
  logic                      out_normal_ready;
  logic                      in_downstream_ready;
  logic                      out_flit_valid;
  types::flit_t              out_flit;
  logic                      out_flit_is_sys;
  logic                      out_overflow;
  logic [DROP_CNT_WIDTH-1:0] out_drop_count;

  // Arbiter side
  modport slave (
    input  in_sys_flit_valid, in_sys_flit, in_normal_flit_valid, in_normal_flit,
    input  in_downstream_ready,
    output out_sys_ready, out_normal_ready, out_flit_valid, out_flit, out_flit_is_sys,
    output out_overflow, out_drop_count
  );

  // Pipeline / downstream side
  modport master (
    output in_sys_flit_valid, in_sys_flit, in_normal_flit_valid, in_normal_flit,
    output in_downstream_ready,
    input  out_sys_ready, out_normal_ready, out_flit_valid, out_flit, out_flit_is_sys,
    input  out_overflow, out_drop_count
  );
endinterface

// File: rtl/stage30_flit_output_arbiter.sv
// Stage-30 output arbiter: one holding slot per path (sys / normal),
// system-priority arbitration with a burst cap, registered output stage.

// One-entry holding slot. Captures only while empty; a pop frees it on the
// same edge, so a refill lands one edge later at the earliest.
module stage30_flit_output_arbiter_slot (
  input  logic         nocclk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  types::flit_t in_flit,
  input  logic         pop,
  output logic         full,
  output types::flit_t data,
  output logic         ovf
);
  // Slot occupancy and payload
  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (full) begin
      if (pop) full <= 1'b0;
    end else if (in_valid) begin
      full <= 1'b1;
      data <= in_flit;
    end
  end

  // Offered flit that has nowhere to go this edge
  assign ovf = in_valid & full;
endmodule

module stage30_flit_output_arbiter #(
  parameter int SYS_BURST_MAX  = 4,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                           nocclk,
  input  logic                           rst_n,
  stage30_flit_output_arbiter_if.slave   bus
);
  localparam int NUM_SLOTS = 2;
  localparam int SYS       = 0;
  localparam int NRM       = 1;
  localparam logic [3:0] BURST_MAX = 4'(SYS_BURST_MAX);

  typedef enum logic [1:0] {ARB_IDLE, ARB_SYS, ARB_NORMAL} arb_state_e;

  logic [NUM_SLOTS-1:0]         slot_vld, slot_full, slot_pop, slot_ovf;
  types::flit_t [NUM_SLOTS-1:0] slot_in, slot_data;

  arb_state_e state_q, state_n;
  logic [3:0] burst_q, burst_n;
  logic       grant_sys, grant_nrm, out_free;

  logic                      out_vld_q, out_sys_q, ovf_q;
  types::flit_t              out_flit_q;
  logic [DROP_CNT_WIDTH-1:0] drop_q;

  assign slot_vld[SYS] = bus.in_sys_flit_valid;
  assign slot_in[SYS]  = bus.in_sys_flit;
  assign slot_vld[NRM] = bus.in_normal_flit_valid;
  assign slot_in[NRM]  = bus.in_normal_flit;
  assign slot_pop[SYS] = grant_sys;
  assign slot_pop[NRM] = grant_nrm;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    stage30_flit_output_arbiter_slot u_slot (
      .nocclk   (nocclk),
      .rst_n    (rst_n),
      .in_valid (slot_vld[g]),
      .in_flit  (slot_in[g]),
      .pop      (slot_pop[g]),
      .full     (slot_full[g]),
      .data     (slot_data[g]),
      .ovf      (slot_ovf[g])
    );
  end

  assign out_free = !out_vld_q || bus.in_downstream_ready;

  // Arbiter state register
  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      burst_q <= '0;
    end else begin
      state_q <= state_n;
      burst_q <= burst_n;
    end
  end

  // Grant selection and next state. The burst counter only counts sys wins
  // while a normal flit waits; it can never pass BURST_MAX because at the cap
  // the normal flit wins, so the increment needs no explicit clamp.
  always_comb begin
    state_n   = state_q;
    burst_n   = burst_q;
    grant_sys = 1'b0;
    grant_nrm = 1'b0;
    if (out_free) begin
      if (!slot_full[NRM]) burst_n = '0;
      unique case (state_q)
        ARB_SYS: begin
          if (slot_full[SYS] && (!slot_full[NRM] || burst_q < BURST_MAX)) begin
            grant_sys = 1'b1;
            if (slot_full[NRM]) burst_n = burst_q + 4'd1;
          end else if (slot_full[NRM]) begin
            grant_nrm = 1'b1;
            burst_n   = '0;
            state_n   = ARB_NORMAL;
          end else begin
            state_n = ARB_IDLE;
          end
        end
        ARB_IDLE, ARB_NORMAL: begin
          if (slot_full[SYS]) begin
            grant_sys = 1'b1;
            burst_n   = slot_full[NRM] ? 4'd1 : 4'd0;
            state_n   = ARB_SYS;
          end else if (slot_full[NRM]) begin
            grant_nrm = 1'b1;
            burst_n   = '0;
            state_n   = ARB_NORMAL;
          end else begin
            state_n = ARB_IDLE;
          end
        end
        default: state_n = ARB_IDLE;
      endcase
    end
  end

  // Output register: loads the winner when free, otherwise holds steady
  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_flit_q <= '0;
      out_sys_q  <= 1'b0;
    end else if (out_free) begin
      out_vld_q <= grant_sys | grant_nrm;
      if (grant_sys | grant_nrm) begin
        out_flit_q <= grant_sys ? slot_data[SYS] : slot_data[NRM];
        out_sys_q  <= grant_sys;
      end
    end
  end

  // Overflow pulse and saturating drop counter; a double overflow is one event
  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      ovf_q <= |slot_ovf;
      if (|slot_ovf && drop_q != '1) drop_q <= drop_q + 1'b1;
    end
  end

  assign bus.out_sys_ready    = !slot_full[SYS];
  assign bus.out_normal_ready = !slot_full[NRM];
  assign bus.out_flit_valid   = out_vld_q;
  assign bus.out_flit         = out_flit_q;
  assign bus.out_flit_is_sys  = out_sys_q;
  assign bus.out_overflow     = ovf_q;
  assign bus.out_drop_count   = drop_q;
endmodule

// File: tb/tb_stage30_flit_output_arbiter.sv
// Bench for the stage-30 output arbiter. Directed scenarios use constant
// expectations; the random scenario compares against a cycle model that
// picks winners from a "sys streak while normal waits" rule.
module tb_stage30_flit_output_arbiter;
  localparam int BMAX = 4;
  localparam int DCW  = 8;

  logic nocclk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 nocclk = ~nocclk;

  stage30_flit_output_arbiter_if #(.DROP_CNT_WIDTH(DCW)) bus ();

  stage30_flit_output_arbiter #(.SYS_BURST_MAX(BMAX), .DROP_CNT_WIDTH(DCW)) dut (
    .nocclk (nocclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit           m_sf, m_nf, m_ov, m_os, m_ovf;
  types::flit_t m_sd, m_nd, m_of;
  int           m_streak, m_drop;

  task automatic model_reset();
    m_sf = 0; m_nf = 0; m_ov = 0; m_os = 0; m_ovf = 0;
    m_sd = '0; m_nd = '0; m_of = '0; m_streak = 0; m_drop = 0;
  endtask

  // Advance one clock edge; model consumes the inputs present before the edge
  task automatic step();
    bit sv, nv, ds, free, ovf;
    int win;
    bit n_sf, n_nf, n_ov, n_os;
    types::flit_t n_sd, n_nd, n_of;
    int n_streak, n_drop;
    sv = bus.in_sys_flit_valid; nv = bus.in_normal_flit_valid; ds = bus.in_downstream_ready;
    free = !m_ov || ds;
    win = 0;
    if (free) begin
      if (m_sf && !(m_nf && m_streak >= BMAX)) win = 1;
      else if (m_nf) win = 2;
    end
    n_streak = m_streak;
    if (free) n_streak = (win == 1 && m_nf) ? m_streak + 1 : 0;
    n_sf = m_sf; n_sd = m_sd; n_nf = m_nf; n_nd = m_nd;
    if (m_sf) begin if (win == 1) n_sf = 0; end
    else if (sv) begin n_sf = 1; n_sd = bus.in_sys_flit; end
    if (m_nf) begin if (win == 2) n_nf = 0; end
    else if (nv) begin n_nf = 1; n_nd = bus.in_normal_flit; end
    ovf = (sv && m_sf) || (nv && m_nf);
    n_ov = m_ov; n_of = m_of; n_os = m_os;
    if (free) begin
      n_ov = (win != 0);
      if (win == 1) begin n_of = m_sd; n_os = 1; end
      if (win == 2) begin n_of = m_nd; n_os = 0; end
    end
    n_drop = (ovf && m_drop < 255) ? m_drop + 1 : m_drop;
    @(posedge nocclk);
    m_sf = n_sf; m_sd = n_sd; m_nf = n_nf; m_nd = n_nd;
    m_ov = n_ov; m_of = n_of; m_os = n_os; m_ovf = ovf;
    m_streak = n_streak; m_drop = n_drop;
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_sys_flit_valid = 0; bus.in_sys_flit = '0;
    bus.in_normal_flit_valid = 0; bus.in_normal_flit = '0;
    bus.in_downstream_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    @(posedge nocclk); @(posedge nocclk);
    #3 rst_n = 1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.out_flit_valid, bus.out_flit, bus.out_flit_is_sys, bus.out_sys_ready,
         bus.out_normal_ready, bus.out_overflow, bus.out_drop_count} !==
        {1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0}) begin
      errors++;
      $display("FAIL reset_state: got v=%b f=%h s=%b sr=%b nr=%b o=%b d=%0d, want 0/0/0/1/1/0/0",
               bus.out_flit_valid, bus.out_flit, bus.out_flit_is_sys, bus.out_sys_ready,
               bus.out_normal_ready, bus.out_overflow, bus.out_drop_count);
    end
  endtask

  task automatic test_single_sys();
    do_reset();
    bus.in_sys_flit_valid = 1; bus.in_sys_flit = 32'hA5;
    step();
    bus.in_sys_flit_valid = 0;
    checks++;
    if ({bus.out_sys_ready, bus.out_flit_valid} !== 2'b00) begin
      errors++;
      $display("FAIL single_e0: got ready=%b valid=%b, want 0 0", bus.out_sys_ready, bus.out_flit_valid);
    end
    step();
    checks++;
    if ({bus.out_flit_valid, bus.out_flit, bus.out_flit_is_sys} !== {1'b1, 32'hA5, 1'b1}) begin
      errors++;
      $display("FAIL single_e1: got v=%b f=%h s=%b, want 1 a5 1",
               bus.out_flit_valid, bus.out_flit, bus.out_flit_is_sys);
    end
    step();
    checks++;
    if (bus.out_flit_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_e2: got valid=%b, want 0", bus.out_flit_valid);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.in_sys_flit_valid = 1; bus.in_sys_flit = 32'h111;
    bus.in_normal_flit_valid = 1; bus.in_normal_flit = 32'h222;
    step();
    bus.in_sys_flit_valid = 0; bus.in_normal_flit_valid = 0;
    step();
    checks++;
    if ({bus.out_flit_valid, bus.out_flit, bus.out_flit_is_sys} !== {1'b1, 32'h111, 1'b1}) begin
      errors++;
      $display("FAIL simul_first: got v=%b f=%h s=%b, want 1 111 1",
               bus.out_flit_valid, bus.out_flit, bus.out_flit_is_sys);
    end
    step();
    checks++;
    if ({bus.out_flit_valid, bus.out_flit, bus.out_flit_is_sys} !== {1'b1, 32'h222, 1'b0}) begin
      errors++;
      $display("FAIL simul_second: got v=%b f=%h s=%b, want 1 222 0",
               bus.out_flit_valid, bus.out_flit, bus.out_flit_is_sys);
    end
  endtask

  // Both slots refilled whenever ready; downstream accepts every other cycle
  // so each arbitration sees both slots full.
  task automatic test_burst_limit();
    bit q[$];
    int first_n, run;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      bus.in_sys_flit_valid    = bus.out_sys_ready;
      bus.in_sys_flit          = 32'h5000_0000 | c;
      bus.in_normal_flit_valid = bus.out_normal_ready;
      bus.in_normal_flit       = 32'h6000_0000 | c;
      bus.in_downstream_ready  = c[0];
      if (bus.out_flit_valid && bus.in_downstream_ready) q.push_back(bus.out_flit_is_sys);
      step();
    end
    idle_inputs();
    repeat (4) step();
    first_n = -1;
    for (int i = 0; i < q.size(); i++) if (first_n < 0 && q[i] == 1'b0) first_n = i;
    checks++;
    if (first_n != BMAX) begin
      errors++;
      $display("FAIL burst_first_streak: got %0d sys grants before first normal, want %0d", first_n, BMAX);
    end
    run = 0;
    if (first_n >= 0)
      for (int i = first_n + 1; i < q.size() && q[i] == 1'b1; i++) run++;
    checks++;
    if (run != BMAX || first_n < 0 || first_n + run + 2 >= q.size()) begin
      errors++;
      $display("FAIL burst_streak: got run=%0d (n=%0d of %0d), want %0d", run, first_n, q.size(), BMAX);
    end else begin
      checks++;
      if ({q[first_n + run + 1], q[first_n + run + 2]} !== 2'b01) begin
        errors++;
        $display("FAIL burst_resume: got %b%b, want 01", q[first_n + run + 1], q[first_n + run + 2]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.in_downstream_ready = 0;
    bus.in_sys_flit_valid = 1; bus.in_sys_flit = 32'hB1;
    step();
    bus.in_sys_flit_valid = 0;
    step();
    bus.in_sys_flit_valid = 1; bus.in_sys_flit = 32'hB2;
    bus.in_normal_flit_valid = 1; bus.in_normal_flit = 32'hC1;
    step();
    bus.in_sys_flit_valid = 0; bus.in_normal_flit_valid = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.out_flit_valid, bus.out_flit, bus.out_flit_is_sys, bus.out_sys_ready, bus.out_normal_ready}
          !== {1'b1, 32'hB1, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b f=%h s=%b sr=%b nr=%b, want 1 b1 1 0 0", i,
                 bus.out_flit_valid, bus.out_flit, bus.out_flit_is_sys, bus.out_sys_ready, bus.out_normal_ready);
      end
      step();
    end
    bus.in_downstream_ready = 1;
    step();
    checks++;
    if ({bus.out_flit_valid, bus.out_flit, bus.out_flit_is_sys} !== {1'b1, 32'hB2, 1'b1}) begin
      errors++;
      $display("FAIL bp_drain_sys: got v=%b f=%h s=%b, want 1 b2 1",
               bus.out_flit_valid, bus.out_flit, bus.out_flit_is_sys);
    end
    step();
    checks++;
    if ({bus.out_flit_valid, bus.out_flit, bus.out_flit_is_sys} !== {1'b1, 32'hC1, 1'b0}) begin
      errors++;
      $display("FAIL bp_drain_nrm: got v=%b f=%h s=%b, want 1 c1 0",
               bus.out_flit_valid, bus.out_flit, bus.out_flit_is_sys);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.in_downstream_ready = 0;
    bus.in_sys_flit_valid = 1; bus.in_sys_flit = 32'hD1;
    step();
    bus.in_sys_flit_valid = 0;
    step();
    bus.in_sys_flit_valid = 1; bus.in_sys_flit = 32'hD2;
    bus.in_normal_flit_valid = 1; bus.in_normal_flit = 32'hE1;
    step();
    bus.in_normal_flit_valid = 0; bus.in_sys_flit = 32'hD3;
    step();
    bus.in_sys_flit_valid = 0;
    checks++;
    if ({bus.out_overflow, bus.out_drop_count} !== {1'b1, 8'd1}) begin
      errors++;
      $display("FAIL ovf_pulse: got o=%b d=%0d, want 1 1", bus.out_overflow, bus.out_drop_count);
    end
    step();
    checks++;
    if ({bus.out_overflow, bus.out_drop_count} !== {1'b0, 8'd1}) begin
      errors++;
      $display("FAIL ovf_end: got o=%b d=%0d, want 0 1", bus.out_overflow, bus.out_drop_count);
    end
    bus.in_sys_flit_valid = 1; bus.in_sys_flit = 32'hD4;
    bus.in_normal_flit_valid = 1; bus.in_normal_flit = 32'hE2;
    step();
    bus.in_sys_flit_valid = 0; bus.in_normal_flit_valid = 0;
    checks++;
    if ({bus.out_overflow, bus.out_drop_count, bus.out_flit} !== {1'b1, 8'd2, 32'hD1}) begin
      errors++;
      $display("FAIL ovf_double: got o=%b d=%0d f=%h, want 1 2 d1",
               bus.out_overflow, bus.out_drop_count, bus.out_flit);
    end
    bus.in_downstream_ready = 1;
    step();
    checks++;
    if ({bus.out_flit, bus.out_flit_is_sys} !== {32'hD2, 1'b1}) begin
      errors++;
      $display("FAIL ovf_kept_sys: got f=%h s=%b, want d2 1", bus.out_flit, bus.out_flit_is_sys);
    end
    step();
    checks++;
    if ({bus.out_flit, bus.out_flit_is_sys} !== {32'hE1, 1'b0}) begin
      errors++;
      $display("FAIL ovf_kept_nrm: got f=%h s=%b, want e1 0", bus.out_flit, bus.out_flit_is_sys);
    end
    step();
    bus.in_downstream_ready = 0;
    bus.in_sys_flit_valid = 1;
    for (int i = 0; i < 300; i++) begin
      bus.in_sys_flit = $urandom;
      step();
    end
    bus.in_normal_flit_valid = 1; bus.in_normal_flit = 32'hE3;
    step(); step();
    checks++;
    if (bus.out_drop_count !== 8'd255) begin
      errors++;
      $display("FAIL ovf_saturate: got %0d, want 255", bus.out_drop_count);
    end
  endtask

  // Continues from the full state left by test_overflow
  task automatic test_async_reset();
    #2 rst_n = 0;
    #1;
    checks++;
    if ({bus.out_flit_valid, bus.out_flit, bus.out_flit_is_sys, bus.out_sys_ready,
         bus.out_normal_ready, bus.out_overflow, bus.out_drop_count} !==
        {1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0}) begin
      errors++;
      $display("FAIL async_reset: got v=%b f=%h s=%b sr=%b nr=%b o=%b d=%0d, want 0/0/0/1/1/0/0",
               bus.out_flit_valid, bus.out_flit, bus.out_flit_is_sys, bus.out_sys_ready,
               bus.out_normal_ready, bus.out_overflow, bus.out_drop_count);
    end
    model_reset();
    idle_inputs();
    @(posedge nocclk);
    #3 rst_n = 1;
    bus.in_sys_flit_valid = 1; bus.in_sys_flit = 32'hE5;
    step();
    bus.in_sys_flit_valid = 0;
    checks++;
    if (bus.out_flit_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_lat1: got valid=%b after 1 edge, want 0", bus.out_flit_valid);
    end
    step();
    checks++;
    if ({bus.out_flit_valid, bus.out_flit, bus.out_flit_is_sys} !== {1'b1, 32'hE5, 1'b1}) begin
      errors++;
      $display("FAIL async_lat2: got v=%b f=%h s=%b, want 1 e5 1",
               bus.out_flit_valid, bus.out_flit, bus.out_flit_is_sys);
    end
  endtask

  task automatic test_random();
    logic [44:0] got, exp;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bus.in_sys_flit_valid    = ($urandom % 3) == 0;
      bus.in_sys_flit          = $urandom;
      bus.in_normal_flit_valid = ($urandom % 2) == 0;
      bus.in_normal_flit       = $urandom;
      bus.in_downstream_ready  = ($urandom % 4) != 0;
      step();
      got = {bus.out_flit_valid, bus.out_flit, bus.out_flit_is_sys, bus.out_sys_ready,
             bus.out_normal_ready, bus.out_overflow, bus.out_drop_count};
      exp = {m_ov, m_of, m_os, !m_sf, !m_nf, m_ovf, 8'(m_drop)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random[%0d]: got %h, want %h (v,flit,sys,sr,nr,ovf,drop)", c, got, exp);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_single_sys();
    test_simultaneous();
    test_burst_limit();
    test_backpressure();
    test_overflow();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stage30_flit_output_arbiter.md
Name: stage30_flit_output_arbiter

Overview:
- Merges the two stage-30 generator outputs into the single router output stream: the system-flit path (sys_flit_out) and the normal-flit path (normal_flit_out).
- Each path gets a one-entry holding slot. A registered output stage honours downstream backpressure.
- Arbitration gives system flits priority, with a burst limit so normal traffic is not starved.
- Ready signals go back to the stage-30 pipeline so it stalls instead of losing flits.

Parameters:
- SYS_BURST_MAX, 4: maximum consecutive system grants while a normal flit is waiting. Legal range 1..15.
- DROP_CNT_WIDTH, 8: width of the saturating overflow counter.

Ports:
- nocclk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_sys_flit_valid, input, 1: system flit present this cycle.
- in_sys_flit, input, types::flit_t: system flit.
- in_normal_flit_valid, input, 1: normal flit present this cycle.
- in_normal_flit, input, types::flit_t: normal flit.
- out_sys_ready, output, 1: system slot empty, so a flit can be accepted this cycle.
- out_normal_ready, output, 1: normal slot empty, so a flit can be accepted this cycle.
- in_downstream_ready, input, 1: downstream accepts out_flit this cycle.
- out_flit_valid, output, 1: output flit valid.
- out_flit, output, types::flit_t: output flit.
- out_flit_is_sys, output, 1: the current out_flit came from the system path.
- out_overflow, output, 1: one-cycle pulse when a valid input arrived while its slot was full.
- out_drop_count, output, DROP_CNT_WIDTH: saturating count of overflow events.

Behaviour:
- Reset (asynchronous, rst_n low): both slots empty; output register empty.
  - out_flit_valid=0, out_flit='0, out_flit_is_sys=0.
  - out_sys_ready=1, out_normal_ready=1.
  - out_overflow=0, out_drop_count=0, burst counter=0, arbiter state=ARB_IDLE.
  - Reset mid-operation discards all held flits; no partial output.
- Slot capture: on a clock edge, a slot loads its input when its valid is 1 and the slot is empty.
  - out_*_ready is the registered slot-empty flag. It does not depend combinationally on in_downstream_ready.
  - Valid while the slot is full: the flit is discarded, the slot keeps its old content, and out_overflow pulses for 1 cycle.
  - out_drop_count increments and saturates at all-ones.
  - Simultaneous sys and normal overflows count as 1 event.
- Output register "free" = (!out_flit_valid) || in_downstream_ready.
  - A flit held on out_flit stays stable until in_downstream_ready=1.
- Arbitration happens when the output register is free and at least one slot is full. The winner's slot is moved into the output register and freed on the same edge.
  - A slot freed on edge E shows ready=1 from E onward.
  - A slot emptied at E can capture a new flit at E+1 at the earliest; no same-edge refill.
- Latency: input presented before edge E0 is captured at E0. If the output is free, out_flit_valid=1 after E1. Minimum is 2 edges.
- Arbiter FSM:
  - ARB_IDLE: no grant last cycle. Sys full → grant sys, burst=1, go to ARB_SYS. Else normal full → grant normal, go to ARB_NORMAL.
  - ARB_SYS:
    - Sys full and (normal empty or burst<SYS_BURST_MAX) → grant sys; burst += 1, saturating at SYS_BURST_MAX.
    - Else normal full → grant normal, burst=0, go to ARB_NORMAL.
    - Else → ARB_IDLE.
  - ARB_NORMAL: sys full → grant sys, burst=1, go to ARB_SYS. Else normal full → grant normal. Else → ARB_IDLE.
  - No grant while the output register is not free: FSM state and burst counter hold.
  - The burst counter resets to 0 whenever normal is empty at an arbitration point. The limit applies only while normal is waiting.
- out_flit_is_sys is registered with out_flit and reflects the winning path.
- Flits are passed through unmodified; the block does no header decoding.

Test Plan:
- Reset, then one sys flit 0xA5 and no backpressure.
  - Required: out_sys_ready=0 after E0; out_flit=0xA5 with out_flit_valid=1 and out_flit_is_sys=1 after E1; valid drops after E2.
- Sys and normal flits presented the same cycle, downstream ready.
  - Required: sys flit out first, normal flit on the following cycle.
- Normal slot kept full; sys refilled every time out_sys_ready=1; SYS_BURST_MAX=4.
  - Required: exactly 4 sys grants, then 1 normal grant, then the sys streak resumes.
- in_downstream_ready=0 for 5 cycles with a flit on the output.
  - Required: out_flit and out_flit_is_sys stable throughout; slots keep data; no loss.
  - Then ready=1 drains in priority order.
- Sys slot full and held by backpressure, second sys valid presented.
  - Required: out_overflow pulses 1 cycle; drop count=1; the original flit is delivered.
  - Additional overflow events saturate the count at 255.
- rst_n asserted asynchronously mid-cycle with both slots and the output full.
  - Required: all outputs at reset values immediately; the first flit after release is delivered with 2-edge latency.
